// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect/stall controls from
// later stages, and the registered instruction slot presented to decode.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 20
);
    logic                   stall;
    logic                   branchTaken;
    logic [ADDR_WIDTH-1:0]  branchTarget;
    logic [ADDR_WIDTH-1:0]  imemAddress;
    logic                   imemReadEnable;
    logic [INSTR_WIDTH-1:0] imemData;
    logic                   imemReady;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instructionValid;
    logic [ADDR_WIDTH-1:0]  instructionPC;

    modport master (
        input  stall, branchTaken, branchTarget, imemData, imemReady,
        output imemAddress, imemReadEnable, instruction, instructionValid, instructionPC
    );

    modport slave (
        output stall, branchTaken, branchTarget, imemData, imemReady,
        input  imemAddress, imemReadEnable, instruction, instructionValid, instructionPC
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, ready-handshake word reads, stall hold and branch redirect.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer behind the output slot.
module instruction_fetch #(
    parameter int unsigned          ADDR_WIDTH  = 8,
    parameter int unsigned          INSTR_WIDTH = 20,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                 clock,
    input logic                 reset,
    instruction_fetch_if.master fetch_bus
);

    typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  fetch_addr_q, fetch_addr_d;
    logic                   req_q, req_d;
    logic [INSTR_WIDTH-1:0] slot_data_q, slot_data_d;
    logic [ADDR_WIDTH-1:0]  slot_pc_q, slot_pc_d;
    logic                   slot_valid_q, slot_valid_d;
`ifdef FETCH_PREFETCH_EN
    logic [INSTR_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [ADDR_WIDTH-1:0]  buf_pc_q, buf_pc_d;
    logic                   buf_valid_q, buf_valid_d;
`endif

    logic handshake;
    logic waiting;
    logic slot_free;
    logic accepted;
    logic hold_full;

    assign handshake = req_q & fetch_bus.imemReady;
    assign waiting   = req_q & ~fetch_bus.imemReady;
    assign slot_free = ~slot_valid_q | ~fetch_bus.stall;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        req_d        = req_q;
        slot_data_d  = slot_data_q;
        slot_pc_d    = slot_pc_q;
        slot_valid_d = slot_valid_q;
`ifdef FETCH_PREFETCH_EN
        buf_data_d   = buf_data_q;
        buf_pc_d     = buf_pc_q;
        buf_valid_d  = buf_valid_q;
`endif
        accepted     = 1'b0;
        hold_full    = 1'b0;

        // Decode takes the slot (or it is empty); the buffered word moves up behind it.
        if (slot_free) begin
`ifdef FETCH_PREFETCH_EN
            slot_valid_d = buf_valid_q;
            buf_valid_d  = 1'b0;
            if (buf_valid_q) begin
                slot_data_d = buf_data_q;
                slot_pc_d   = buf_pc_q;
            end
`else
            slot_valid_d = 1'b0;
`endif
        end

        unique case (state_q)
            StFetch: begin
                req_d = 1'b1;
                if (handshake) begin
                    if (!slot_valid_d) begin
                        slot_valid_d = 1'b1;
                        slot_data_d  = fetch_bus.imemData;
                        slot_pc_d    = fetch_addr_q;
                        accepted     = 1'b1;
                    end
`ifdef FETCH_PREFETCH_EN
                    else if (!buf_valid_d) begin
                        buf_valid_d = 1'b1;
                        buf_data_d  = fetch_bus.imemData;
                        buf_pc_d    = fetch_addr_q;
                        accepted    = 1'b1;
                    end
`endif
                end
                // A word with nowhere to go is dropped; pc stays put so it is refetched.
                if (accepted) begin
                    pc_d         = pc_q + 1'b1;
                    fetch_addr_d = pc_q + 1'b1;
                end
`ifdef FETCH_PREFETCH_EN
                hold_full = slot_valid_q & buf_valid_d;
`else
                hold_full = slot_valid_q;
`endif
                if (fetch_bus.stall && hold_full && !waiting) begin
                    state_d = StHold;
                    req_d   = 1'b0;
                end
            end
            StHold: begin
                req_d = 1'b0;
                if (!fetch_bus.stall) begin
                    state_d      = StFetch;
                    req_d        = 1'b1;
                    fetch_addr_d = pc_q;
                end
            end
            StDiscard: begin
                req_d = 1'b1;
                if (fetch_bus.imemReady) begin
                    state_d      = StFetch;
                    fetch_addr_d = pc_q;
                end
            end
            default: begin
                state_d = StFetch;
                req_d   = 1'b1;
            end
        endcase

        // Redirect wins over everything; an unfinished read must still drain at its old address.
        if (fetch_bus.branchTaken) begin
            pc_d         = fetch_bus.branchTarget;
            slot_valid_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
            buf_valid_d  = 1'b0;
`endif
            req_d        = 1'b1;
            if (waiting) begin
                state_d      = StDiscard;
                fetch_addr_d = fetch_addr_q;
            end else begin
                state_d      = StFetch;
                fetch_addr_d = fetch_bus.branchTarget;
            end
        end

        if (!slot_valid_d) begin
            slot_data_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            req_q        <= 1'b0;
            slot_data_q  <= '0;
            slot_pc_q    <= RESET_PC;
            slot_valid_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            buf_data_q   <= '0;
            buf_pc_q     <= RESET_PC;
            buf_valid_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            req_q        <= req_d;
            slot_data_q  <= slot_data_d;
            slot_pc_q    <= slot_pc_d;
            slot_valid_q <= slot_valid_d;
`ifdef FETCH_PREFETCH_EN
            buf_data_q   <= buf_data_d;
            buf_pc_q     <= buf_pc_d;
            buf_valid_q  <= buf_valid_d;
`endif
        end
    end

    assign fetch_bus.imemAddress      = fetch_addr_q;
    assign fetch_bus.imemReadEnable   = req_q;
    assign fetch_bus.instruction      = slot_data_q;
    assign fetch_bus.instructionValid = slot_valid_q;
    assign fetch_bus.instructionPC    = slot_pc_q;

endmodule
